cdb_wb_arbiter: RTL and testbench
=================================

CDB_WB_ARBITER -- requirements
Module: cdb_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_WB, default 5, meaning the number of writeback requesters, indexed 0=arith, 1=mult, 2=mem, 3=br, 4=div.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1 bit: synchronous kill of all pending writebacks.
REQ-005 SHALL have port fu_valid, input, NUM_WB bits: requester i presents a result.
REQ-006 SHALL have port fu_ready, output, NUM_WB bits: requester i's result is accepted this cycle.
REQ-007 SHALL have port fu_pd, input, NUM_WB x PHYS_REG_ADDR bits: destination physical register.
REQ-008 SHALL have port fu_val, input, NUM_WB x 32 bits: result value.
REQ-009 SHALL have port fu_rob, input, NUM_WB x ROB_IDX_W bits: ROB tag of the result.
REQ-010 SHALL have port regf_we, output, 1 bit: register-file write enable.
REQ-011 SHALL have port rd_s, output, PHYS_REG_ADDR bits: register-file write address.
REQ-012 SHALL have port rd_v, output, 32 bits: register-file write data.
REQ-013 SHALL have port cdb_valid, output, 1 bit: a broadcast occurs this cycle.
REQ-014 SHALL have port cdb_rob, output, ROB_IDX_W bits: ROB tag of the broadcast.
REQ-015 SHALL drive rd_s and rd_v as the CDB tag and data, so no separate tag/data ports exist.

Function
REQ-016 SHALL hold one holding entry per requester (occupied bit plus pd, val, rob).
REQ-017 SHALL capture the inputs into entry i on a clock edge where fu_valid[i] && fu_ready[i].
REQ-018 SHALL drive fu_ready[i] = !flush && (!occupied[i] || grant[i]), a same-cycle pass-through when the entry drains.
REQ-019 SHALL select at most one occupied entry per cycle by round-robin; grant is combinational from the entries.
REQ-020 SHALL give priority, starting at rr_ptr, in increasing index with wrap-around from NUM_WB-1 to 0.
REQ-021 SHALL set rr_ptr to (granted index + 1) mod NUM_WB after a grant, and leave it unchanged when there is no grant.
REQ-022 SHALL drive cdb_valid=1 when any entry is granted, with rd_s, rd_v and cdb_rob taken from the granted entry.
REQ-023 SHALL drive regf_we = cdb_valid && (rd_s != 0); a p0 destination broadcasts for ROB completion but never writes the register file.
REQ-024 SHALL clear entry i's occupied bit on the edge ending its grant cycle, unless it is refilled that same edge.
REQ-025 SHALL use a latency of exactly 1 cycle from acceptance to the earliest broadcast; no entry waits more than NUM_WB-1 cycles after becoming occupied.
REQ-026 SHALL, when flush=1, force cdb_valid=0, regf_we=0 and fu_ready=0, and clear all occupied bits on that edge; rr_ptr SHALL be unchanged.
REQ-027 SHALL drive rd_s=0, rd_v=0 and cdb_rob=0 when there is no grant.
REQ-028 SHALL never grant an unoccupied entry and never grant two entries in one cycle.

Reset
REQ-029 SHALL, on rst low and asynchronously, clear all occupied bits and set rr_ptr=0, giving outputs regf_we=0, cdb_valid=0, rd_s=0, rd_v=0, cdb_rob=0 and fu_ready=all ones.
REQ-030 SHALL have entry payload registers that need no reset.
REQ-031 SHALL, when reset is asserted mid-operation, drop all pending results with no partial broadcast.

Structure
REQ-032 SHALL take PHYS_REG_ADDR, ROB_IDX_W and NUM_WB_PORTS from package module_types, together with a wb_entry_t struct {pd, val, rob}.
REQ-033 SHALL have grant logic in one sub-module rr_arbiter (request vector, pointer, one-hot grant, parameterised by N), and nothing else.

Verification
REQ-034 SHALL be verified for single request: arith pd=7, val=0xDEADBEEF, rob=3 accepted at cycle 0 -> cycle 1 regf_we=1, rd_s=7, rd_v=0xDEADBEEF, cdb_rob=3; cycle 2 cdb_valid=0.
REQ-035 SHALL be verified for contention: all 5 requesters accepted at cycle 0 with rr_ptr=0 -> grants 0,1,2,3,4 in cycles 1-5; fu_ready[i]=0 while entry i waits.
REQ-036 SHALL be verified for fairness: mult requests every cycle, with mem accepted at cycle 1 -> mem is broadcast no later than cycle 3, and rr_ptr wraps 4->0.
REQ-037 SHALL be verified for p0: br result with pd=0, rob=9 -> cdb_valid=1, cdb_rob=9, regf_we=0.
REQ-038 SHALL be verified for flush: 3 occupied entries, flush=1 for one cycle -> no broadcast that cycle or the next, fu_ready=0 during flush, all ones after.
REQ-039 SHALL be verified for reset: rst dropped mid-contention between edges -> outputs reach reset values immediately; the first post-reset request grants with rr_ptr=0.

Source files
------------

// File: rtl/module_types.sv
// Shared writeback types: register/ROB widths, requester count and the
// per-requester holding entry payload.
package module_types;
  localparam int PHYS_REG_ADDR = 6;
  localparam int ROB_IDX_W     = 5;
  localparam int NUM_WB_PORTS  = 5;

  typedef struct packed {
    logic [PHYS_REG_ADDR-1:0] pd;
    logic [31:0]              val;
    logic [ROB_IDX_W-1:0]     rob;
  } wb_entry_t;

  typedef enum logic [2:0] {
    WB_ARITH = 3'd0,
    WB_MULT  = 3'd1,
    WB_MEM   = 3'd2,
    WB_BR    = 3'd3,
    WB_DIV   = 3'd4
  } wb_src_e;
endpackage

// File: rtl/cdb_wb_arbiter_if.sv
// Functional-unit writeback request bus, one lane per requester.
// Handshake: lane i transfers on a rising edge where fu_valid[i] && fu_ready[i];
// payload (fu_pd/fu_val/fu_rob) is only meaningful while fu_valid[i] is high.
interface cdb_wb_arbiter_if
  import module_types::*;
#(
  parameter int NUM_WB = NUM_WB_PORTS
);
  logic [NUM_WB-1:0]                     fu_valid;
  logic [NUM_WB-1:0]                     fu_ready;
  logic [NUM_WB-1:0][PHYS_REG_ADDR-1:0]  fu_pd;
  logic [NUM_WB-1:0][31:0]               fu_val;
  logic [NUM_WB-1:0][ROB_IDX_W-1:0]      fu_rob;

  modport master (output fu_valid, fu_pd, fu_val, fu_rob, input fu_ready);
  modport slave  (input fu_valid, fu_pd, fu_val, fu_rob, output fu_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first set request at or after ptr, wrapping
// from N-1 back to 0.
module rr_arbiter #(
  parameter  int N     = 5,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_wb_arbiter.sv
// Common data bus writeback arbiter: one holding entry per functional unit,
// round-robin broadcast of one entry per cycle onto the CDB / register file port.
module cdb_wb_arbiter
  import module_types::*;
#(
  parameter int NUM_WB = NUM_WB_PORTS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  cdb_wb_arbiter_if.slave          fu,
  output logic                     regf_we,
  output logic [PHYS_REG_ADDR-1:0] rd_s,
  output logic [31:0]              rd_v,
  output logic                     cdb_valid,
  output logic [ROB_IDX_W-1:0]     cdb_rob
);
  localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic [NUM_WB-1:0] occ;
  logic [NUM_WB-1:0] raw_gnt;
  logic [NUM_WB-1:0] gnt;
  logic [NUM_WB-1:0] accept;
  wb_entry_t         ent [NUM_WB];
  wb_entry_t         sel;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  rr_ptr_nxt;

  rr_arbiter #(.N(NUM_WB)) u_rr (
    .req (occ),
    .ptr (rr_ptr),
    .gnt (raw_gnt)
  );

  // Flush suppresses the grant so neither the CDB nor rr_ptr moves that cycle.
  assign gnt         = flush ? '0 : raw_gnt;
  assign fu.fu_ready = ~{NUM_WB{flush}} & (~occ | gnt);
  assign accept      = fu.fu_valid & fu.fu_ready;

  always_comb begin
    sel     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (gnt[i]) begin
        sel     = ent[i];
        gnt_idx = PTR_W'(i);
      end
    end
  end

  assign rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_WB - 1)) ? '0 : gnt_idx + PTR_W'(1);

  assign cdb_valid = |gnt;
  assign rd_s      = sel.pd;
  assign rd_v      = sel.val;
  assign cdb_rob   = sel.rob;
  // p0 is the hardwired zero register: broadcast for completion, never written.
  assign regf_we   = cdb_valid && (sel.pd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ    <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      occ    <= '0;
    end else begin
      occ <= accept | (occ & ~gnt);
      if (cdb_valid) rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WB; i++) begin
      if (accept[i]) begin
        ent[i].pd  <= fu.fu_pd[i];
        ent[i].val <= fu.fu_val[i];
        ent[i].rob <= fu.fu_rob[i];
      end
    end
  end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter: directed scenarios followed by random traffic,
// all checked against an occupancy/round-robin reference model.
module tb_cdb_wb_arbiter;
  import module_types::*;

  localparam int N  = NUM_WB_PORTS;
  localparam int BW = ROB_IDX_W + PHYS_REG_ADDR + 32;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic                     regf_we;
  logic [PHYS_REG_ADDR-1:0] rd_s;
  logic [31:0]              rd_v;
  logic                     cdb_valid;
  logic [ROB_IDX_W-1:0]     cdb_rob;

  cdb_wb_arbiter_if #(.NUM_WB(N)) bus ();

  cdb_wb_arbiter #(.NUM_WB(N)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .flush     (flush),
    .fu        (bus.slave),
    .regf_we   (regf_we),
    .rd_s      (rd_s),
    .rd_v      (rd_v),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_occ [N];
  wb_entry_t   m_ent [N];
  int          m_ptr;
  int          m_gnt;
  logic [N-1:0] m_ready;
  logic [BW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    m_ptr = 0;
    m_gnt = -1;
    exp_q.delete();
  endtask

  function automatic int model_grant();
    if (flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (m_occ[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic [PHYS_REG_ADDR-1:0] pd,
                         input logic [31:0] val, input logic [ROB_IDX_W-1:0] rob);
    bus.fu_valid[i] = 1'b1;
    bus.fu_pd[i]    = pd;
    bus.fu_val[i]   = val;
    bus.fu_rob[i]   = rob;
  endtask

  task automatic clear_reqs();
    bus.fu_valid = '0;
    bus.fu_pd    = '0;
    bus.fu_val   = '0;
    bus.fu_rob   = '0;
  endtask

  // settle, then compare every output against the model
  task automatic eval();
    logic [PHYS_REG_ADDR-1:0] e_pd;
    logic [31:0]              e_val;
    logic [ROB_IDX_W-1:0]     e_rob;
    #1;
    m_gnt = model_grant();
    for (int i = 0; i < N; i++) m_ready[i] = !flush && (!m_occ[i] || m_gnt == i);
    e_pd = '0; e_val = '0; e_rob = '0;
    if (m_gnt >= 0) begin
      e_pd  = m_ent[m_gnt].pd;
      e_val = m_ent[m_gnt].val;
      e_rob = m_ent[m_gnt].rob;
      exp_q.push_back({e_rob, e_pd, e_val});
    end
    chk("cdb_valid", 64'(cdb_valid), 64'(m_gnt >= 0));
    chk("regf_we",   64'(regf_we),   64'((m_gnt >= 0) && (e_pd != '0)));
    chk("rd_s",      64'(rd_s),      64'(e_pd));
    chk("rd_v",      64'(rd_v),      64'(e_val));
    chk("cdb_rob",   64'(cdb_rob),   64'(e_rob));
    chk("fu_ready",  64'(bus.fu_ready), 64'(m_ready));
    if (cdb_valid === 1'b1 && exp_q.size() > 0)
      chk("sb_bcast", 64'({cdb_rob, rd_s, rd_v}), 64'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  // clock edge, then advance the model by the rules of acceptance/grant/flush
  task automatic advance();
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.fu_valid[i] && m_ready[i]) begin
          m_occ[i]     = 1'b1;
          m_ent[i].pd  = bus.fu_pd[i];
          m_ent[i].val = bus.fu_val[i];
          m_ent[i].rob = bus.fu_rob[i];
        end else if (i == m_gnt) begin
          m_occ[i] = 1'b0;
        end
      end
      if (m_gnt >= 0) m_ptr = (m_gnt + 1) % N;
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(0));
    chk({tag, "_we"},    64'(regf_we),   64'(0));
    chk({tag, "_rd_s"},  64'(rd_s),      64'(0));
    chk({tag, "_rd_v"},  64'(rd_v),      64'(0));
    chk({tag, "_rob"},   64'(cdb_rob),   64'(0));
    chk({tag, "_ready"}, 64'(bus.fu_ready), 64'(5'h1f));
  endtask

  int mem_seen;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_reqs();
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // contention: all five accepted together with rr_ptr=0
    for (int i = 0; i < N; i++)
      set_req(i, PHYS_REG_ADDR'(i + 1), $urandom, ROB_IDX_W'(10 + i));
    eval(); advance();
    clear_reqs();
    for (int c = 1; c <= N; c++) begin
      eval();
      chk($sformatf("contend_rob_c%0d", c), 64'(cdb_rob), 64'(10 + c - 1));
      chk($sformatf("contend_ready_c%0d", c), 64'(bus.fu_ready), 64'((1 << c) - 1));
      advance();
    end

    // pointer wrapped 4->0: arith wins over mult
    set_req(1, PHYS_REG_ADDR'(2), 32'h1111_0001, ROB_IDX_W'(21));
    set_req(0, PHYS_REG_ADDR'(1), 32'h1111_0000, ROB_IDX_W'(20));
    eval(); advance();
    clear_reqs();
    eval(); chk("wrap_first", 64'(cdb_rob), 64'(20)); advance();
    eval(); chk("wrap_second", 64'(cdb_rob), 64'(21)); advance();

    // single request, one-cycle latency
    set_req(0, PHYS_REG_ADDR'(7), 32'hDEAD_BEEF, ROB_IDX_W'(3));
    eval(); advance();
    clear_reqs();
    eval();
    chk("single_we",   64'(regf_we), 64'(1));
    chk("single_rd_s", 64'(rd_s),    64'(7));
    chk("single_rd_v", 64'(rd_v),    64'(32'hDEAD_BEEF));
    chk("single_rob",  64'(cdb_rob), 64'(3));
    advance();
    eval(); chk("single_idle", 64'(cdb_valid), 64'(0)); advance();

    // fairness: mult every cycle, mem arrives at cycle 1
    mem_seen = -1;
    for (int c = 0; c < 6; c++) begin
      set_req(1, PHYS_REG_ADDR'(5), $urandom, ROB_IDX_W'(20 + c));
      if (c == 1) set_req(2, PHYS_REG_ADDR'(6), 32'h0000_0A0A, ROB_IDX_W'(30));
      else bus.fu_valid[2] = 1'b0;
      eval();
      if (cdb_valid && cdb_rob == ROB_IDX_W'(30) && mem_seen < 0) mem_seen = c;
      advance();
    end
    clear_reqs();
    eval(); advance();
    eval(); advance();
    chk("fair_mem_by_cycle3", 64'(mem_seen >= 2 && mem_seen <= 3), 64'(1));

    // p0 destination: broadcast without register write
    set_req(3, PHYS_REG_ADDR'(0), $urandom, ROB_IDX_W'(9));
    eval(); advance();
    clear_reqs();
    eval();
    chk("p0_valid", 64'(cdb_valid), 64'(1));
    chk("p0_rob",   64'(cdb_rob),   64'(9));
    chk("p0_we",    64'(regf_we),   64'(0));
    advance();

    // flush with three occupied entries
    set_req(0, PHYS_REG_ADDR'(3), $urandom, ROB_IDX_W'(1));
    set_req(2, PHYS_REG_ADDR'(4), $urandom, ROB_IDX_W'(2));
    set_req(4, PHYS_REG_ADDR'(5), $urandom, ROB_IDX_W'(4));
    eval(); advance();
    clear_reqs();
    flush = 1'b1;
    eval();
    chk("flush_valid", 64'(cdb_valid), 64'(0));
    chk("flush_ready", 64'(bus.fu_ready), 64'(0));
    advance();
    flush = 1'b0;
    eval();
    chk("post_flush_valid", 64'(cdb_valid), 64'(0));
    chk("post_flush_ready", 64'(bus.fu_ready), 64'(5'h1f));
    advance();

    // reset mid-contention after three grants move rr_ptr away from 0
    for (int i = 0; i < N; i++)
      set_req(i, PHYS_REG_ADDR'(i + 8), $urandom, ROB_IDX_W'(i));
    eval(); advance();
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      eval(); advance();
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(3, PHYS_REG_ADDR'(13), $urandom, ROB_IDX_W'(13));
    set_req(1, PHYS_REG_ADDR'(11), $urandom, ROB_IDX_W'(11));
    eval(); advance();
    clear_reqs();
    eval(); chk("rst_first_grant", 64'(cdb_rob), 64'(11)); advance();
    eval(); advance();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(i,
                  ($urandom_range(0, 7) == 0) ? PHYS_REG_ADDR'(0)
                                              : PHYS_REG_ADDR'($urandom_range(1, 63)),
                  $urandom,
                  ROB_IDX_W'($urandom_range(0, 31)));
        else
          bus.fu_valid[i] = 1'b0;
      end
      eval(); advance();
    end
    flush = 1'b0;
    clear_reqs();
    for (int c = 0; c < 6; c++) begin
      eval(); advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
